fighter_motion: RTL and testbench

//  Per-fighter movement controller, directly upstream of the sprite renderer. Samples player
//  key levels once per video frame, runs an IDLE/WALK/CROUCH/JUMP state machine with gravity,
//  and drives the registered sprite top-left position (AkumaX/AkumaY), facing, and walk

---
 rtl/fighter_motion.sv | 215 +++++++++++++++++++++
 tb/tb_fighter_motion.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_motion.sv
// ---------------------------------------------------------------------------
// fighter_motion
//   Per-fighter movement controller that sits directly in front of the sprite
//   renderer. Key levels are sampled once per video frame, on the falling edge
//   of vsync. An IDLE/WALK/CROUCH/JUMP state machine with gravity then updates
//   the registered sprite position, the facing flag and the walk animation
//   frame. Every output is a register that changes only on a frame tick, so
//   the renderer never sees the position move in the middle of a frame.
//
// Ports
//   vga_clk     in   pixel clock; all state changes on its rising edge
//   reset_n     in   asynchronous, active-low reset
//   vs          in   VGA vsync, active low; its falling edge marks a frame
//   key_left    in   level, move left
//   key_right   in   level, move right
//   key_up      in   level, jump
//   key_down    in   level, crouch
//   opp_x       in   opponent left column; used only to decide facing
//   AkumaX      out  sprite left column
//   AkumaY      out  sprite top row
//   facing_left out  1 when the opponent is to the left
//   motion_st   out  00 IDLE, 01 WALK, 10 CROUCH, 11 JUMP
//   anim_frame  out  walk animation index 0..3
// ---------------------------------------------------------------------------
module fighter_motion #(
    parameter int SPRITE_W   = 105,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 640 - SPRITE_W,
    parameter int GROUND_Y   = 280,
    parameter int START_X    = 100,
    parameter int WALK_SPEED = 3,
    parameter int JUMP_V0    = 15,
    parameter int GRAVITY    = 1,
    parameter int ANIM_DIV   = 8
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vs,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [9:0] opp_x,
    output logic [9:0] AkumaX,
    output logic [9:0] AkumaY,
    output logic       facing_left,
    output logic [1:0] motion_st,
    output logic [1:0] anim_frame
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WALK   = 2'b01,
        CROUCH = 2'b10,
        JUMP   = 2'b11
    } state_t;

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    // Constants pre-sized to the 11-bit signed arithmetic width.
    localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
    localparam logic signed [10:0] GROUND_S   = 11'(GROUND_Y);
    localparam logic signed [7:0]  WALK_S     = 8'(WALK_SPEED);
    localparam logic signed [7:0]  JUMP_V0_S  = 8'(JUMP_V0);
    localparam logic signed [7:0]  GRAVITY_S  = 8'(GRAVITY);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(ANIM_DIV - 1);

    state_t             state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic               facing_q, facing_d;
    logic [1:0]         anim_q, anim_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [7:0]  vy_q, vy_d;
    logic signed [7:0]  drift_q, drift_d;
    logic               vs_d;

    logic               tick;
    logic               only_left, only_right;
    logic signed [7:0]  walk_delta;
    logic signed [10:0] x_ext, y_ext;
    logic signed [10:0] drift_ext, walk_ext, vy_ext;
    logic signed [10:0] x_walk_sum, x_drift_sum, y_sum;

    // Clamp an unwrapped 11-bit column back into the legal window.
    function automatic logic [9:0] clamp_x(input logic signed [10:0] v);
        if (v < X_MIN_S) begin
            return X_MIN_S[9:0];
        end else if (v > X_MAX_S) begin
            return X_MAX_S[9:0];
        end
        return v[9:0];
    endfunction

    // One-cycle strobe on the falling edge of vsync.
    assign tick = vs_d & ~vs;

    // Opposing horizontal keys cancel each other.
    assign only_left  = key_left & ~key_right;
    assign only_right = key_right & ~key_left;
    assign walk_delta = only_left ? -WALK_S : WALK_S;

    // Sign-extend everything to 11 bits so sums cannot wrap.
    assign x_ext       = {1'b0, x_q};
    assign y_ext       = {1'b0, y_q};
    assign drift_ext   = {{3{drift_q[7]}}, drift_q};
    assign walk_ext    = {{3{walk_delta[7]}}, walk_delta};
    assign vy_ext      = {{3{vy_q[7]}}, vy_q};
    assign x_walk_sum  = x_ext + walk_ext;
    assign x_drift_sum = x_ext + drift_ext;
    assign y_sum       = y_ext - vy_ext;

    always_comb begin
        // NOTE: every next-state value is given a hold default first, so no
        // path through the branches below can leave one unassigned (latch).
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        facing_d = facing_q;
        anim_d   = anim_q;
        cnt_d    = cnt_q;
        vy_d     = vy_q;
        drift_d  = drift_q;

        if (tick) begin
            // Facing freezes while airborne; an equal column keeps the old value.
            if (state_q != JUMP) begin
                if (opp_x < x_q) begin
                    facing_d = 1'b1;
                end else if (opp_x > x_q) begin
                    facing_d = 1'b0;
                end
            end

            if (state_q == JUMP) begin
                // Keys are ignored in the air; drift was latched at takeoff.
                x_d = clamp_x(x_drift_sum);
                if (y_sum >= GROUND_S) begin
                    state_d = IDLE;
                    y_d     = GROUND_S[9:0];
                    vy_d    = '0;
                    drift_d = '0;
                end else begin
                    y_d  = y_sum[9:0];
                    vy_d = vy_q - GRAVITY_S;
                end
            end else if (key_up) begin
                // Position is untouched on the takeoff tick itself.
                state_d = JUMP;
                vy_d    = JUMP_V0_S;
                if (only_left) begin
                    drift_d = -WALK_S;
                end else if (only_right) begin
                    drift_d = WALK_S;
                end else begin
                    drift_d = '0;
                end
            end else if (key_down) begin
                state_d = CROUCH;
            end else if (only_left || only_right) begin
                state_d = WALK;
                x_d     = clamp_x(x_walk_sum);
            end else begin
                state_d = IDLE;
            end

            // The walk cycle advances only while in WALK; anything else rewinds it.
            if (state_d == WALK) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    anim_d = anim_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d  = '0;
                anim_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x_q      <= 10'(START_X);
            y_q      <= GROUND_S[9:0];
            facing_q <= 1'b0;
            anim_q   <= '0;
            cnt_q    <= '0;
            vy_q     <= '0;
            drift_q  <= '0;
            vs_d     <= 1'b1;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            facing_q <= facing_d;
            anim_q   <= anim_d;
            cnt_q    <= cnt_d;
            vy_q     <= vy_d;
            drift_q  <= drift_d;
            vs_d     <= vs;
        end
    end

    assign AkumaX      = x_q;
    assign AkumaY      = y_q;
    assign facing_left = facing_q;
    assign motion_st   = state_q;
    assign anim_frame  = anim_q;

endmodule

// File: tb/tb_fighter_motion.sv
// ---------------------------------------------------------------------------
// tb_fighter_motion
//   Directed bench for fighter_motion. Frames are generated by pulsing vs low
//   for one clock; inputs change on the falling clock edge and outputs are
//   sampled there too, half a period away from the active edge. Expected
//   values are hand-computed from the movement rules.
// ---------------------------------------------------------------------------
module tb_fighter_motion;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       vs = 1'b1;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic [9:0] opp_x = 10'd200;
    logic [9:0] AkumaX;
    logic [9:0] AkumaY;
    logic       facing_left;
    logic [1:0] motion_st;
    logic [1:0] anim_frame;

    int checks = 0;
    int failures = 0;

    fighter_motion dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .vs          (vs),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_up      (key_up),
        .key_down    (key_down),
        .opp_x       (opp_x),
        .AkumaX      (AkumaX),
        .AkumaY      (AkumaY),
        .facing_left (facing_left),
        .motion_st   (motion_st),
        .anim_frame  (anim_frame)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: vs low for one clock, then high for two.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge vga_clk);
            vs = 1'b0;
            @(negedge vga_clk);
            vs = 1'b1;
            @(negedge vga_clk);
        end
    endtask

    task automatic set_keys(input logic l, input logic r, input logic u, input logic d);
        key_left  = l;
        key_right = r;
        key_up    = u;
        key_down  = d;
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        reset_n = 1'b0;
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
    endtask

    initial begin
        do_reset();

        // 1. Idle frames leave the fighter at the start position.
        check("rst_x", AkumaX, 100);
        check("rst_y", AkumaY, 280);
        check("rst_st", motion_st, 0);
        check("rst_anim", anim_frame, 0);
        check("rst_face", facing_left, 0);
        ticks(5);
        check("idle_x", AkumaX, 100);
        check("idle_y", AkumaY, 280);
        check("idle_st", motion_st, 0);
        check("idle_anim", anim_frame, 0);

        // 2. Walk left: 3 px per tick, animation steps on the 8th WALK tick.
        set_keys(1, 0, 0, 0);
        ticks(7);
        check("walk7_x", AkumaX, 79);
        check("walk7_anim", anim_frame, 0);
        ticks(1);
        check("walk8_x", AkumaX, 76);
        check("walk8_anim", anim_frame, 1);
        ticks(2);
        check("walk10_x", AkumaX, 70);
        check("walk10_st", motion_st, 1);
        check("walk10_anim", anim_frame, 1);

        // left+right cancel: back to IDLE, animation rewound.
        set_keys(1, 1, 0, 0);
        ticks(1);
        check("lr_st", motion_st, 0);
        check("lr_x", AkumaX, 70);
        check("lr_anim", anim_frame, 0);

        // 3. Left clamp at 0, right clamp at 535.
        set_keys(1, 0, 0, 0);
        ticks(23);
        check("left23_x", AkumaX, 1);
        ticks(1);
        check("left_clamp_x", AkumaX, 0);
        ticks(5);
        check("left_hold_x", AkumaX, 0);
        set_keys(0, 1, 0, 0);
        ticks(178);
        check("right178_x", AkumaX, 534);
        ticks(1);
        check("right_clamp_x", AkumaX, 535);
        ticks(3);
        check("right_hold_x", AkumaX, 535);

        // down beats left/right and holds X.
        set_keys(0, 1, 0, 1);
        ticks(1);
        check("crouch_st", motion_st, 2);
        check("crouch_x", AkumaX, 535);
        check("crouch_anim", anim_frame, 0);

        // 4. Vertical jump; facing updates at takeoff then freezes in the air.
        do_reset();
        check("rst2_face", facing_left, 0);
        opp_x = 10'd50;
        set_keys(0, 0, 1, 0);
        ticks(1);
        check("takeoff_st", motion_st, 3);
        check("takeoff_y", AkumaY, 280);
        check("takeoff_x", AkumaX, 100);
        check("takeoff_face", facing_left, 1);
        set_keys(1, 0, 0, 1);
        opp_x = 10'd500;
        ticks(15);
        check("apex_y", AkumaY, 160);
        check("apex_st", motion_st, 3);
        check("air_x", AkumaX, 100);
        check("air_face", facing_left, 1);
        ticks(15);
        check("fall30_y", AkumaY, 265);
        check("fall30_st", motion_st, 3);
        ticks(1);
        check("land_y", AkumaY, 280);
        check("land_st", motion_st, 0);
        check("land_x", AkumaX, 100);
        check("land_face", facing_left, 1);
        set_keys(0, 0, 0, 0);
        ticks(1);
        check("face_right", facing_left, 0);
        opp_x = 10'd100;
        ticks(1);
        check("face_eq0", facing_left, 0);
        opp_x = 10'd50;
        ticks(1);
        check("face_left", facing_left, 1);
        opp_x = 10'd100;
        ticks(1);
        check("face_eq1", facing_left, 1);

        // 5. Jump with right drift: +3 per air tick including landing.
        do_reset();
        set_keys(0, 1, 1, 0);
        ticks(1);
        check("drift_takeoff_x", AkumaX, 100);
        set_keys(0, 0, 0, 0);
        ticks(30);
        check("drift30_x", AkumaX, 190);
        ticks(1);
        check("drift_land_x", AkumaX, 193);
        check("drift_land_y", AkumaY, 280);
        check("drift_land_st", motion_st, 0);

        // Drift clamps at the right edge.
        do_reset();
        set_keys(0, 1, 0, 0);
        ticks(145);
        check("edge_x", AkumaX, 535);
        set_keys(0, 1, 1, 0);
        ticks(1);
        set_keys(0, 0, 0, 0);
        ticks(7);
        check("edge_air_x", AkumaX, 535);
        check("edge_air_y", AkumaY, 196);
        check("edge_air_st", motion_st, 3);

        // 6. Asynchronous reset mid-jump, visible before any clock edge.
        @(posedge vga_clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_x", AkumaX, 100);
        check("async_y", AkumaY, 280);
        check("async_st", motion_st, 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);

        // No vs fall: keys have no effect.
        set_keys(1, 0, 1, 0);
        repeat (20) @(negedge vga_clk);
        check("novs_x", AkumaX, 100);
        check("novs_y", AkumaY, 280);
        check("novs_st", motion_st, 0);
        set_keys(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
